load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the byte-addressed data-RAM interface: takes one load or store request at a time from the execute stage and computes `addr = base + offset`. Drives the RAM's `addr`/`sel`/`dataWrite` lines for exactly one cycle, captures and extends read data, and returns a one-cycle response. It sits between the pipeline's MEM stage and the 4 KiB big-endian data RAM, where `mem[addr]` is the most significant byte.

## Interface
- `ADDR_LIMIT`, default 4096: RAM size in bytes; any access whose last byte lies at or beyond this limit is rejected.
- `IDLE_SEL`, default 4'b1111: `memSel` value that the RAM treats as no operation.
- `clk`  in  1: rising-edge clock; the only clock.
- `rst`  in  1: reset, asynchronous and active-high.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: unit can accept; high only in IDLE.
- `req_store`  in  1: 1 = store, 0 = load.
- `req_funct3`  in  3: RISC-V width code. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_base`  in  32: base register value.
- `req_offset`  in  32: sign-extended immediate.
- `req_wdata`  in  32: store data; the low bytes are used.
- `resp_valid`  out  1: one-cycle response pulse.
- `resp_data`  out  32: extended load data; 0 for stores and errors.
- `resp_err`  out  1: misaligned, out-of-range or illegal request.
- `memAddr`  out  32: RAM byte address.
- `memSel`  out  4: `{size/sign[2:0], read}`. `sel[0]` = 1 for read, 0 for write.
- `memDataWrite`  out  32: RAM write data.
- `memData`  in  32: RAM read data; combinational from `memAddr`/`memSel`.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`, register `addr`, `funct3`, `store` and `wdata`, then check the request.
  - Illegal request, any of:
    - store with `funct3` in {100, 101};
    - any `funct3` in {011, 110, 111};
    - H/HU with `addr[0]` = 1;
    - W with `addr[1:0]` ≠ 0;
    - `addr + size − 1 ≥ ADDR_LIMIT`, computed without 32-bit wrap.
  - Illegal request → set `err`, go to RESP. No memory cycle is issued.
  - Legal request → go to ACCESS.
- **ACCESS** (exactly one cycle)
  - `memAddr` = `addr`.
  - `memSel` = `{funct3, ~store}`.
  - `memDataWrite` = `wdata`.
  - At the end of the cycle, a load captures `memData`. The unit re-extends from the low bits itself and does not trust the upper bits:
    - B: sign-extend bit 7.
    - BU: zero-extend bits 7:0.
    - H: sign-extend bit 15.
    - HU: zero-extend bits 15:0.
    - W: as is.
  - Go to RESP.
- **RESP**
  - `resp_valid` = 1.
  - `resp_data` and `resp_err` hold the result.
  - Go to IDLE unconditionally. There is no back-pressure on responses.
- Outside ACCESS:
  - `memSel` = `IDLE_SEL`.
  - `memAddr` and `memDataWrite` hold their last values, so the RAM sees no spurious write event.
- `req_valid` while not in IDLE is ignored. The requester must hold the request until `req_ready`.
- Address arithmetic is modulo 2^32; the range check catches wrapped results.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE;
  - `req_ready` = 1, `resp_valid` = 0, `resp_data` = 0, `resp_err` = 0;
  - `memAddr` = 0, `memSel` = `IDLE_SEL`, `memDataWrite` = 0.
- All outputs are registered.
- Request accepted at edge N:
  - `memSel` is valid during cycle N+1;
  - `resp_valid` is high from edge N+2 to edge N+3.
- Latency is 2 cycles; throughput is one request per 3 cycles. A back-to-back `req_valid` is accepted at edge N+3.
- Error path: accepted at N, `resp_valid` is high from N+1 to N+2. Throughput is one per 2 cycles.
- Store: the RAM write is visible from cycle N+1. `memSel` returns to `IDLE_SEL` at edge N+2.
- Reset during ACCESS: `memSel` drops to `IDLE_SEL` immediately. No response is produced. A partially driven store is allowed to complete in the RAM.

## Test plan
- LW, base=0x100, offset=4, RAM[0x104..0x107]=DE AD BE EF:
  - `memSel`=0101 in cycle N+1;
  - `resp_data`=0xDEADBEEF, `resp_err`=0 at N+2.
- LB vs LBU at 0x010, RAM=0x80:
  - LB → 0xFFFFFF80;
  - LBU → 0x00000080;
  - LH at 0x010 with RAM 0x80 0x01 → 0xFFFF8001.
- SH, addr 0x020, wdata=0x1234ABCD:
  - `memSel`=0010 for exactly one cycle;
  - a following LHU at 0x020 returns 0x0000ABCD.
- Misaligned and illegal requests → `resp_err`=1, `resp_data`=0, `resp_valid` at N+1, and `memSel` stays 1111 throughout:
  - LW at 0x102;
  - LH at 0x011;
  - SW at 0xFFE;
  - store with `funct3`=100.
- Back-to-back requests with `req_valid` held high: accepted at edges 0 and 3, responses at edges 2 and 5.
- Assert `rst` mid-ACCESS of a load: all outputs go to their reset values immediately, with no `resp_valid`; the next request completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store initiator for the byte-addressed big-endian data RAM.
// Takes one request at a time, drives the RAM for one cycle and returns a one-cycle response.
module load_store_unit #(
    parameter int unsigned ADDR_LIMIT = 4096,
    parameter logic [3:0]  IDLE_SEL   = 4'b1111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [31:0] req_offset,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [31:0] memAddr,
    output logic [3:0]  memSel,
    output logic [31:0] memDataWrite,
    input  logic [31:0] memData
);

    localparam int unsigned XW = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state, state_d;

    logic [XW-1:0] addr_q;
    logic [XW-1:0] wdata_q;
    logic [2:0]    funct3_q;
    logic          store_q;
    logic          err_q;

    logic [XW-1:0] req_addr;
    logic [2:0]    size_m1;
    logic [XW:0]   last_byte;
    logic          req_err;
    logic          accept;
    logic [XW-1:0] load_data;

    logic          req_ready_d;
    logic          resp_valid_d;
    logic [XW-1:0] resp_data_d;
    logic          resp_err_d;
    logic [XW-1:0] mem_addr_d;
    logic [3:0]    mem_sel_d;
    logic [XW-1:0] mem_wdata_d;

    // Request legality; the last-byte sum is one bit wider so a wrapped address stays out of range.
    always_comb begin
        req_addr = req_base + req_offset;
        case (req_funct3[1:0])
            2'b00:   size_m1 = 3'd0;
            2'b01:   size_m1 = 3'd1;
            2'b10:   size_m1 = 3'd3;
            default: size_m1 = 3'd0;
        endcase
        last_byte = {1'b0, req_addr} + (XW+1)'(size_m1);
        req_err   = 1'b0;
        if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111)
            req_err = 1'b1;
        if (req_store && req_funct3[2])
            req_err = 1'b1;
        if (req_funct3[1:0] == 2'b01 && req_addr[0])
            req_err = 1'b1;
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
        if (last_byte >= (XW+1)'(ADDR_LIMIT))
            req_err = 1'b1;
    end

    // Re-extend from the low bits only; the RAM's upper bits are not trusted.
    always_comb begin
        case (funct3_q)
            3'b000:  load_data = {{24{memData[7]}}, memData[7:0]};
            3'b100:  load_data = {24'd0, memData[7:0]};
            3'b001:  load_data = {{16{memData[15]}}, memData[15:0]};
            3'b101:  load_data = {16'd0, memData[15:0]};
            3'b010:  load_data = memData;
            default: load_data = '0;
        endcase
    end

    always_comb begin
        state_d      = state;
        accept       = 1'b0;
        resp_valid_d = 1'b0;
        resp_data_d  = '0;
        resp_err_d   = 1'b0;
        mem_addr_d   = memAddr;
        mem_sel_d    = IDLE_SEL;
        mem_wdata_d  = memDataWrite;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = req_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_addr_d  = addr_q;
                mem_sel_d   = {funct3_q, ~store_q};
                mem_wdata_d = wdata_q;
                state_d     = RESP;
            end
            RESP: begin
                resp_valid_d = 1'b1;
                resp_err_d   = err_q;
                resp_data_d  = (err_q || store_q) ? '0 : load_data;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            resp_err     <= 1'b0;
            memAddr      <= '0;
            memSel       <= IDLE_SEL;
            memDataWrite <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            funct3_q     <= '0;
            store_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state        <= state_d;
            req_ready    <= req_ready_d;
            resp_valid   <= resp_valid_d;
            resp_data    <= resp_data_d;
            resp_err     <= resp_err_d;
            memAddr      <= mem_addr_d;
            memSel       <= mem_sel_d;
            memDataWrite <= mem_wdata_d;
            if (accept) begin
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                funct3_q <= req_funct3;
                store_q  <= req_store;
                err_q    <= req_err;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: behavioural RAM, byte-array reference model,
// driver pushes expectations, monitor checks RAM drive and responses.
module tb_load_store_unit;

    localparam int unsigned LIMIT = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base, req_offset, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_data;
    logic [31:0] memAddr, memDataWrite, memData;
    logic [3:0]  memSel;

    load_store_unit #(.ADDR_LIMIT(LIMIT), .IDLE_SEL(4'b1111)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .memAddr(memAddr), .memSel(memSel), .memDataWrite(memDataWrite),
        .memData(memData)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    int          exp_sel_cyc = -1;
    logic [3:0]  exp_sel = 4'hF;
    logic [31:0] exp_addr = 0, exp_wd = 0;
    logic        exp_store = 1'b0;
    logic [31:0] last_data = 0;
    logic        last_err = 1'b0;

    // Behavioural big-endian RAM with garbage in the unused upper read bits
    bit [7:0]    ram [LIMIT];
    bit [7:0]    ref_mem [LIMIT];
    logic [31:0] junk = 0;
    logic [11:0] ra;
    assign ra = memAddr[11:0];

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) junk <= $urandom;

    always_comb begin
        memData = junk;
        if (memSel != 4'b1111 && memSel[0]) begin
            case (memSel[2:1])
                2'b00:   memData[7:0]  = ram[ra];
                2'b01:   memData[15:0] = {ram[ra], ram[ra + 12'd1]};
                default: memData = {ram[ra], ram[ra + 12'd1], ram[ra + 12'd2], ram[ra + 12'd3]};
            endcase
        end
    end

    always @(posedge clk) begin
        if (!rst && memSel != 4'b1111 && !memSel[0]) begin
            case (memSel[2:1])
                2'b00: ram[ra] <= memDataWrite[7:0];
                2'b01: begin
                    ram[ra]         <= memDataWrite[15:8];
                    ram[ra + 12'd1] <= memDataWrite[7:0];
                end
                default: begin
                    ram[ra]         <= memDataWrite[31:24];
                    ram[ra + 12'd1] <= memDataWrite[23:16];
                    ram[ra + 12'd2] <= memDataWrite[15:8];
                    ram[ra + 12'd3] <= memDataWrite[7:0];
                end
            endcase
        end
    end

    // Reference: access size from the width code, legality by arithmetic, bytes from ref_mem
    task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] d, output logic e);
        int     size;
        longint v;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        if (size == 0) e = 1'b1;
        else e = (st && f3 >= 3'd4) || ((longint'(a) % size) != 0) ||
                 (longint'(a) + size - 1 >= longint'(LIMIT));
        d = 0;
        if (!e && st)
            for (int i = 0; i < size; i++)
                ref_mem[a + i] = 8'(wd >> (8 * (size - 1 - i)));
        if (!e && !st) begin
            v = 0;
            for (int i = 0; i < size; i++) v = v * 256 + longint'(ref_mem[a + i]);
            if (f3 < 3'd4 && size < 4 && v >= (64'sd1 << (8 * size - 1)))
                v = v - (64'sd1 << (8 * size));
            d = 32'(v);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_data"}, resp_data, 32'd0);
        chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        chk({tag, "_memAddr"}, memAddr, 32'd0);
        chk({tag, "_memSel"}, 32'(memSel), 32'hF);
        chk({tag, "_memDataWrite"}, memDataWrite, 32'd0);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] b,
                         input logic [31:0] o, input logic [31:0] wd, input bit keep,
                         output int acc);
        logic [31:0] d;
        logic        e;
        int          n;
        req_store = st; req_funct3 = f3; req_base = b; req_offset = o; req_wdata = wd;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        acc = -1;
        if (!req_ready) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout actual req_ready=%b required 1 within 20 cycles", req_ready);
        end else begin
            acc = cyc + 1;
            model(st, f3, b + o, wd, d, e);
            sb.push_back('{d, e, acc + (e ? 1 : 2)});
            if (!e) begin
                exp_sel_cyc = acc + 1;
                exp_sel     = {f3, ~st};
                exp_addr    = b + o;
                exp_wd      = wd;
                exp_store   = st;
            end
        end
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || !req_ready) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) begin
            checks++;
            fails++;
            $display("FAIL idle_timeout actual pending=%0d required 0", sb.size());
        end
    endtask

    // Monitor: RAM drive only in the expected cycle, responses popped from the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (cyc == exp_sel_cyc) begin
                if (memSel !== exp_sel || memAddr !== exp_addr ||
                    (exp_store && memDataWrite !== exp_wd)) begin
                    fails++;
                    $display("FAIL mem_drive cyc=%0d actual sel=%b addr=%h wd=%h required sel=%b addr=%h wd=%h",
                             cyc, memSel, memAddr, memDataWrite, exp_sel, exp_addr, exp_wd);
                end
            end else if (memSel !== 4'b1111) begin
                fails++;
                $display("FAIL mem_idle cyc=%0d actual sel=%b required 1111", cyc, memSel);
            end
            if (resp_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL resp_unexpected cyc=%0d actual data=%h err=%b required no response",
                             cyc, resp_data, resp_err);
                end else begin
                    mon_e = sb.pop_front();
                    if (resp_data !== mon_e.data || resp_err !== mon_e.err || cyc != mon_e.cyc) begin
                        fails++;
                        $display("FAIL resp actual data=%h err=%b cyc=%0d required data=%h err=%b cyc=%0d",
                                 resp_data, resp_err, cyc, mon_e.data, mon_e.err, mon_e.cyc);
                    end
                    last_data = resp_data;
                    last_err  = resp_err;
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                checks++;
                fails++;
                $display("FAIL resp_missing cyc=%0d actual resp_valid=%b required 1", cyc, resp_valid);
                mon_e = sb.pop_front();
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual still running required finish");
        $fatal(1, "watchdog");
    end

    logic [2:0]  codes [16] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2,
                                3'd4, 3'd5, 3'd0, 3'd2, 3'd3, 3'd6, 3'd7, 3'd4};
    logic        e_st  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0]  e_f3  [6] = '{3'd2, 3'd1, 3'd2, 3'd4, 3'd3, 3'd0};
    logic [31:0] e_adr [6] = '{32'h102, 32'h011, 32'hFFE, 32'h030, 32'h040, 32'hFFFFFFFF};

    initial begin
        int          a0, a1;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] b, o;
        req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
        req_base = 0; req_offset = 0; req_wdata = 0;
        #1 rst = 1'b1;
        #2 check_reset("reset");
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // LW of DE AD BE EF at 0x104 after storing it there
        issue(1'b1, 3'b010, 32'h100, 32'h4, 32'hDEADBEEF, 0, a0); wait_idle();
        issue(1'b0, 3'b010, 32'h100, 32'h4, 32'h0, 0, a0); wait_idle();
        chk("lw_data", last_data, 32'hDEADBEEF);
        chk("lw_err", 32'(last_err), 32'd0);

        // Byte/half sign vs zero extension
        issue(1'b1, 3'b000, 32'h10, 32'h0, 32'hAAAAAA80, 0, a0); wait_idle();
        issue(1'b1, 3'b000, 32'h11, 32'h0, 32'h55555501, 0, a0); wait_idle();
        issue(1'b0, 3'b000, 32'h10, 32'h0, 32'h0, 0, a0); wait_idle();
        chk("lb_data", last_data, 32'hFFFFFF80);
        issue(1'b0, 3'b100, 32'h10, 32'h0, 32'h0, 0, a0); wait_idle();
        chk("lbu_data", last_data, 32'h00000080);
        issue(1'b0, 3'b001, 32'h10, 32'h0, 32'h0, 0, a0); wait_idle();
        chk("lh_data", last_data, 32'hFFFF8001);

        // SH then LHU
        issue(1'b1, 3'b001, 32'h20, 32'h0, 32'h1234ABCD, 0, a0); wait_idle();
        issue(1'b0, 3'b101, 32'h20, 32'h0, 32'h0, 0, a0); wait_idle();
        chk("lhu_data", last_data, 32'h0000ABCD);

        // Misaligned, illegal and out-of-range requests
        for (int i = 0; i < 6; i++) begin
            issue(e_st[i], e_f3[i], e_adr[i], 32'h0, 32'hCAFEF00D, 0, a0); wait_idle();
            chk($sformatf("err_flag_%0d", i), 32'(last_err), 32'd1);
            chk($sformatf("err_data_%0d", i), last_data, 32'd0);
        end

        // Boundary-legal: last word of RAM, and a base+offset that wraps to 0
        issue(1'b0, 3'b010, 32'hFFC, 32'h0, 32'h0, 0, a0); wait_idle();
        chk("lw_top_err", 32'(last_err), 32'd0);
        issue(1'b0, 3'b100, 32'hFFFFFFFF, 32'h1, 32'h0, 0, a0); wait_idle();
        chk("lbu_wrap_err", 32'(last_err), 32'd0);

        // Back-to-back with req_valid held
        issue(1'b0, 3'b010, 32'h100, 32'h4, 32'h0, 1, a0);
        issue(1'b0, 3'b000, 32'h10, 32'h0, 32'h0, 0, a1); wait_idle();
        chk("b2b_gap", 32'(a1 - a0), 32'd3);
        issue(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1, a0);
        issue(1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 0, a1); wait_idle();
        chk("b2b_err_gap", 32'(a1 - a0), 32'd2);

        // Reset while the RAM is being driven for a load
        issue(1'b0, 3'b010, 32'h100, 32'h4, 32'h0, 0, a0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset("mid_reset");
        sb.delete();
        exp_sel_cyc = -1;
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        issue(1'b0, 3'b010, 32'h100, 32'h4, 32'h0, 0, a0); wait_idle();
        chk("post_reset_lw", last_data, 32'hDEADBEEF);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            st = 1'($urandom_range(0, 1));
            f3 = codes[$urandom_range(0, 15)];
            if ($urandom_range(0, 9) == 0) b = $urandom;
            else b = 32'($urandom_range(0, 4200));
            o = 32'($urandom_range(0, 255)) - 32'd128;
            if ($urandom_range(0, 1) == 1) begin
                b = b & ~32'h3;
                o = o & ~32'h3;
            end
            issue(st, f3, b, o, $urandom, 0, a0);
            if ($urandom_range(0, 3) == 0) wait_idle();
        end
        wait_idle();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
